ringbuffer_ctrl: RTL and testbench

FIFO controller that drives both ports of the dual-port `buffer` memory, with that memory instantiated alongside it.
Upstream, the LPC/TPM cycle decoder pushes one DW-bit record per strobe. Downstream, the UART transmit stage drains records over a valid/ready handshake.
Owns the write and read pointers, the fill level, and overflow accounting. It does not contain the storage array itself.

---
 rtl/ringbuffer_ctrl.sv | 153 +++++++++++++++
 tb/tb_ringbuffer_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ringbuffer_ctrl.sv
// ringbuffer_ctrl
// ----------------------------------------------------------------------------
// FIFO controller for an external dual-port memory of 2^AW records of DW bits.
// The storage array lives outside this block; this block owns the write and
// read pointers, the fill level, and overflow accounting.
//
// Handshakes:
//   Upstream   : in_strobe pushes in_data for one cycle. There is no
//                backpressure. A push made while the memory is full is dropped
//                and recorded in overflow/drop_count.
//   Downstream : out_data is offered while out_valid=1. It is consumed at a
//                rising edge where out_valid=1 and out_ready=1. While
//                out_valid=1, out_data does not change.
//
// Ports:
//   clock, reset            : system clock; synchronous active-high reset
//   in_data, in_strobe      : push interface from the cycle decoder
//   out_data, out_valid,
//   out_ready               : valid/ready interface to the UART transmit stage
//   level                   : committed entries in memory; the holding register
//                             is not included
//   overflow, drop_count    : sticky drop flag; saturating count of drops
//   buf_write_*             : memory write port (combinational from inputs)
//   buf_read_*              : memory read port; buf_read_data is registered
//                             by the memory one cycle after a read-enabled edge
// ----------------------------------------------------------------------------
module ringbuffer_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_strobe,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic          buf_write_clock_enable,
  output logic [AW-1:0] buf_write_addr,
  output logic [DW-1:0] buf_write_data,
  output logic          buf_read_clock_enable,
  output logic [AW-1:0] buf_read_addr,
  input  logic [DW-1:0] buf_read_data
);

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;

  logic full;
  logic push_ok;
  logic push_drop;
  logic rd_issue;

  // Full is evaluated before this cycle's read issue. A push that arrives
  // while full is therefore dropped, even when a read is issued in the same
  // cycle.
  assign full      = (count_q == CAP);
  assign push_ok   = in_strobe & ~full & ~reset;
  assign push_drop = in_strobe & full & ~reset;
  // A read is issued only for entries counted at an earlier edge. The read
  // therefore never targets the address being written in the same cycle.
  assign rd_issue  = (state_q == ST_IDLE) & (count_q != '0) & ~reset;

  assign buf_write_clock_enable = push_ok;
  assign buf_write_addr         = wptr_q;
  assign buf_write_data         = in_data;
  assign buf_read_clock_enable  = rd_issue;
  assign buf_read_addr          = rptr_q;

  assign level      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

  always_comb begin
    wptr_d     = wptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    unique case ({push_ok, rd_issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= 8'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      unique case (state_q)
        ST_IDLE: begin
          if (rd_issue) begin
            rptr_q  <= rptr_q + 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The memory returns data for the read issued on the previous edge.
          out_data_q  <= buf_read_data;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ringbuffer_ctrl.sv
module tb_ringbuffer_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int CAP = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [DW-1:0] in_data = '0;
  logic          in_strobe = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   level;
  logic          overflow;
  logic [7:0]    drop_count;
  logic          buf_write_clock_enable;
  logic [AW-1:0] buf_write_addr;
  logic [DW-1:0] buf_write_data;
  logic          buf_read_clock_enable;
  logic [AW-1:0] buf_read_addr;
  logic [DW-1:0] buf_read_data;

  ringbuffer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .in_data                (in_data),
    .in_strobe              (in_strobe),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .level                  (level),
    .overflow               (overflow),
    .drop_count             (drop_count),
    .buf_write_clock_enable (buf_write_clock_enable),
    .buf_write_addr         (buf_write_addr),
    .buf_write_data         (buf_write_data),
    .buf_read_clock_enable  (buf_read_clock_enable),
    .buf_read_addr          (buf_read_addr),
    .buf_read_data          (buf_read_data)
  );

  // Dual-port memory that sits beside the controller
  logic [DW-1:0] mem [0:CAP-1];
  always @(posedge clock) begin
    if (buf_write_clock_enable) mem[buf_write_addr] <= buf_write_data;
    if (buf_read_clock_enable)  buf_read_data <= mem[buf_read_addr];
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];   // accepted records not yet consumed, FIFO order
  logic [DW-1:0] rx_q[$];    // records the consumer actually received
  logic [DW-1:0] mq[$];      // records committed to memory
  int            stage = 0;  // 0: nothing in flight, 1: being fetched, 2: offered
  logic [DW-1:0] fly = '0;
  logic [DW-1:0] m_out = '0;
  bit            m_valid = 0;
  bit            m_ovf = 0;
  int            m_drop = 0;
  int            m_wcnt = 0;
  int            m_rcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); mq.delete();
    stage = 0; fly = '0; m_out = '0; m_valid = 0;
    m_ovf = 0; m_drop = 0; m_wcnt = 0; m_rcnt = 0;
  endtask

  task automatic check_regs();
    chk("level",      32'(level),      32'(mq.size()));
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("out_data",   32'(out_data),   32'(m_out));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit s, input logic [DW-1:0] d, input bit r);
    bit acc, iss;
    @(negedge clock);
    in_strobe = s; in_data = d; out_ready = r;
    #1;
    acc = s && (mq.size() < CAP);
    iss = (stage == 0) && (mq.size() != 0);
    chk("wr_en", 32'(buf_write_clock_enable), 32'(acc));
    if (acc) begin
      chk("wr_addr", 32'(buf_write_addr), 32'(m_wcnt % CAP));
      chk("wr_data", 32'(buf_write_data), 32'(d));
    end
    chk("rd_en", 32'(buf_read_clock_enable), 32'(iss));
    if (iss) chk("rd_addr", 32'(buf_read_addr), 32'(m_rcnt % CAP));
    if (out_valid && out_ready) begin
      rx_q.push_back(out_data);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
    end
    @(posedge clock);
    if (acc) exp_q.push_back(d);
    if (s && !acc) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    case (stage)
      0: if (iss) begin fly = mq.pop_front(); m_rcnt++; stage = 1; end
      1: begin m_out = fly; m_valid = 1; stage = 2; end
      default: if (r) begin m_valid = 0; stage = 0; end
    endcase
    if (acc) begin mq.push_back(d); m_wcnt++; end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_strobe = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
    #1;
    chk("rst_wr_en", 32'(buf_write_clock_enable), 32'd0);
    chk("rst_rd_en", 32'(buf_read_clock_enable), 32'd0);
    @(posedge clock);
    model_clear();
    #1;
    reset = 1'b0; in_strobe = 1'b0;
    check_regs();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, then idle
    do_reset();
    idle(5, 1'b1);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single record
    do_reset(); rx_q.delete();
    tick(1'b1, 8'hF1, 1'b1);                       // edge E
    tick(1'b0, 8'h00, 1'b1);                       // edge E+1
    chk("single_e1_valid", 32'(out_valid), 32'd0);
    tick(1'b0, 8'h00, 1'b1);                       // edge E+2
    chk("single_e2_valid", 32'(out_valid), 32'd1);
    chk("single_e2_data",  32'(out_data), 32'hF1);
    tick(1'b0, 8'h00, 1'b1);                       // edge E+3
    chk("single_e3_valid", 32'(out_valid), 32'd0);
    chk("single_level",    32'(level), 32'd0);

    // Ordering with backpressure
    do_reset(); rx_q.delete();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
    idle(3, 1'b0);
    chk("bp_hold_data", 32'(out_data), 32'h10);
    chk("bp_level",     32'(level), 32'd4);
    idle(20, 1'b1);
    chk("bp_rx_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("bp_rx", 32'(rx_q[i]), 32'(8'h10 + i));
    chk("bp_level_end", 32'(level), 32'd0);

    // Overflow
    do_reset(); rx_q.delete();
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(i), 1'b0);
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd3);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_head",  32'(out_data), 32'h00);
    idle(60, 1'b1);
    chk("ovf_rx_count", 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) chk("ovf_rx", 32'(rx_q[i]), 32'(i));

    // Wrap-around: stream past the pointer range several times
    do_reset(); rx_q.delete();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'(8'hA0 + i), 1'b1);
      idle(2, 1'b1);
    end
    idle(6, 1'b1);
    chk("wrap_rx_count", 32'(rx_q.size()), 32'd40);
    chk("wrap_drops",    32'(drop_count), 32'd0);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) chk("wrap_rx", 32'(rx_q[i]), 32'(8'(8'hA0 + i)));

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h30 + i), 1'b0);
    idle(2, 1'b0);
    chk("mid_level", 32'(level), 32'd3);
    chk("mid_valid", 32'(out_valid), 32'd1);
    do_reset(); rx_q.delete();
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf",   32'(overflow), 32'd0);
    tick(1'b1, 8'h55, 1'b1);
    idle(5, 1'b1);
    chk("mid_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() != 0) chk("mid_rx_first", 32'(rx_q[0]), 32'h55);

    // Randomized traffic with stretches of backpressure to provoke drops
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit s, r;
      s = ($urandom_range(0, 99) < 45);
      r = ((i % 150) < 70) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick(s, 8'($urandom), r);
    end
    idle(80, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
